// File: rtl/jtag_tap_pkg.sv
// Shared types and helpers for the oversampled JTAG TAP.
// Contents:
//   tap_state_e    - 4-bit IEEE 1149.1 TAP state encoding (TestLogicReset = 0)
//   IrIdcode       - IDCODE opcode, truncated to the IR width by the user
//   IrBypass       - BYPASS opcode (all ones), truncated to the IR width by the user
//   tap_next_state - TAP next-state function for a given TMS value
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset = 4'h0,
    RunTestIdle    = 4'h1,
    SelectDr       = 4'h2,
    CaptureDr      = 4'h3,
    ShiftDr        = 4'h4,
    Exit1Dr        = 4'h5,
    PauseDr        = 4'h6,
    Exit2Dr        = 4'h7,
    UpdateDr       = 4'h8,
    SelectIr       = 4'h9,
    CaptureIr      = 4'hA,
    ShiftIr        = 4'hB,
    Exit1Ir        = 4'hC,
    PauseIr        = 4'hD,
    Exit2Ir        = 4'hE,
    UpdateIr       = 4'hF
  } tap_state_e;

  localparam logic [31:0] IrIdcode = 32'h0000_0001;
  localparam logic [31:0] IrBypass = 32'hFFFF_FFFF;

  // IEEE 1149.1 TAP transition table
  function automatic tap_state_e tap_next_state(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    case (state)
      TestLogicReset: nxt = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    nxt = tms ? SelectDr       : RunTestIdle;
      SelectDr:       nxt = tms ? SelectIr       : CaptureDr;
      CaptureDr:      nxt = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        nxt = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        nxt = tms ? UpdateDr       : PauseDr;
      PauseDr:        nxt = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        nxt = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       nxt = tms ? SelectDr       : RunTestIdle;
      SelectIr:       nxt = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      nxt = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        nxt = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        nxt = tms ? UpdateIr       : PauseIr;
      PauseIr:        nxt = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        nxt = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       nxt = tms ? SelectDr       : RunTestIdle;
      default:        nxt = TestLogicReset;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Pad-input conditioning for the oversampled TAP: samples TCK/TMS/TDI/TRST
// into clk_i and produces one-cycle TCK rise/fall strobes with TMS/TDI/TRST
// aligned to them.
// Configuration: define JTAG_TAP_SYNC_EN for two-flop synchronizers
// (pad-to-strobe 3 cycles); otherwise a single sampling stage (2 cycles).
// Ports:
//   clk_i, rst_i         - system clock, async active-high reset
//   i_tck/i_tms/i_tdi    - pad JTAG inputs
//   i_trst_n             - pad TRST, active low
//   o_tck_rise/o_tck_fall- one-cycle TCK edge strobes
//   o_tms/o_tdi/o_trst_n - conditioned signals aligned with the strobes
module jtag_tap_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_tck,
  input  logic i_tms,
  input  logic i_tdi,
  input  logic i_trst_n,
  output logic o_tck_rise,
  output logic o_tck_fall,
  output logic o_tms,
  output logic o_tdi,
  output logic o_trst_n
);

  localparam int unsigned NumSig = 4;

  logic [NumSig-1:0] w_pad;
  logic [NumSig-1:0] w_q;
  logic              r_tck_prev;
  logic              r_tck_rise;
  logic              r_tck_fall;
  logic              r_tms;
  logic              r_tdi;
  logic              r_trst_n;

  assign w_pad = {i_tck, i_tms, i_tdi, i_trst_n};

`ifdef JTAG_TAP_SYNC_EN
  logic [NumSig-1:0] r_meta;
  logic [NumSig-1:0] r_sync;

  // Two-flop synchronizer on all pad inputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_pad;
      r_sync <= r_meta;
    end
  end
  assign w_q = r_sync;
`else
  logic [NumSig-1:0] r_sync;

  // Single sampling stage for inputs already synchronous to clk_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= w_pad;
    end
  end
  assign w_q = r_sync;
`endif

  // Edge history plus registered strobes; TMS/TDI/TRST delayed to stay aligned
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tck_prev <= 1'b0;
      r_tck_rise <= 1'b0;
      r_tck_fall <= 1'b0;
      r_tms      <= 1'b0;
      r_tdi      <= 1'b0;
      r_trst_n   <= 1'b0;
    end else begin
      r_tck_prev <= w_q[3];
      r_tck_rise <= w_q[3] & ~r_tck_prev;
      r_tck_fall <= ~w_q[3] & r_tck_prev;
      r_tms      <= w_q[2];
      r_tdi      <= w_q[1];
      r_trst_n   <= w_q[0];
    end
  end

  assign o_tck_rise = r_tck_rise;
  assign o_tck_fall = r_tck_fall;
  assign o_tms      = r_tms;
  assign o_tdi      = r_tdi;
  assign o_trst_n   = r_trst_n;

endmodule

// File: rtl/jtag_tap_oversampled.sv
// IEEE 1149.1 TAP responder running entirely in clk_i, oversampling the pad
// TCK. Provides IDCODE, BYPASS and one user DR with capture/update strobes.
// Configuration: JTAG_TAP_SYNC_EN (see jtag_tap_sync) selects two-flop pad
// synchronizers.
// Ports:
//   clk_i, rst_i           - system clock, async active-high reset
//   jtag_tck_i/tms_i/tdi_i - pad JTAG inputs
//   jtag_trst_ni           - pad TRST, active low
//   jtag_tdo_o, _oe_o      - serial out and its drive enable (Shift states)
//   tap_state_o            - current TAP state
//   user_capture_o/_i      - capture strobe and parallel capture value
//   user_update_o          - update strobe
//   user_data_o            - user shift register contents
module jtag_tap_oversampled
  import jtag_tap_pkg::*;
#(
  parameter int unsigned         IrWidth     = 5,
  parameter logic [31:0]         IdCode      = 32'h1000_0db3,
  parameter int unsigned         UserDrWidth = 41,
  parameter logic [IrWidth-1:0]  UserInstr   = IrWidth'(5'h11)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   jtag_tck_i,
  input  logic                   jtag_tms_i,
  input  logic                   jtag_tdi_i,
  input  logic                   jtag_trst_ni,
  output logic                   jtag_tdo_o,
  output logic                   jtag_tdo_oe_o,
  output logic [3:0]             tap_state_o,
  output logic                   user_capture_o,
  input  logic [UserDrWidth-1:0] user_capture_i,
  output logic                   user_update_o,
  output logic [UserDrWidth-1:0] user_data_o
);

  logic w_tck_rise;
  logic w_tck_fall;
  logic w_tms;
  logic w_tdi;
  logic w_trst_n;
  logic w_adv;

  tap_state_e r_state;
  tap_state_e w_state_nxt;
  logic       w_entering;
  logic       w_capture_nxt;
  logic       w_update_nxt;
  logic       w_tdo_oe_nxt;
  logic       r_user_capture;
  logic       r_user_update;
  logic       r_tdo_oe;
  logic       r_tdo;

  logic [IrWidth-1:0]     r_ir;
  logic [IrWidth-1:0]     r_ir_sr;
  logic [31:0]            r_idcode_sr;
  logic [UserDrWidth-1:0] r_user_sr;
  logic                   r_bypass;
  logic                   w_sel_idcode;
  logic                   w_sel_user;
  logic                   w_dr_lsb;

  jtag_tap_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_tck      (jtag_tck_i),
    .i_tms      (jtag_tms_i),
    .i_tdi      (jtag_tdi_i),
    .i_trst_n   (jtag_trst_ni),
    .o_tck_rise (w_tck_rise),
    .o_tck_fall (w_tck_fall),
    .o_tms      (w_tms),
    .o_tdi      (w_tdi),
    .o_trst_n   (w_trst_n)
  );

  // TRST beats a coincident TCK rise, so shifting is suppressed while it is low
  assign w_adv = w_tck_rise & w_trst_n;

  // DR select; all-ones stays BYPASS even if it collides with UserInstr
  assign w_sel_idcode = (r_ir == IrWidth'(IrIdcode));
  assign w_sel_user   = ~w_sel_idcode && (r_ir == UserInstr) && (r_ir != IrWidth'(IrBypass));
  assign w_dr_lsb     = w_sel_idcode ? r_idcode_sr[0] :
                        w_sel_user   ? r_user_sr[0]   : r_bypass;

  // Next state and registered-output precursors
  always_comb begin
    w_state_nxt   = r_state;
    w_entering    = 1'b0;
    w_capture_nxt = 1'b0;
    w_update_nxt  = 1'b0;
    w_tdo_oe_nxt  = 1'b0;
    if (!w_trst_n) begin
      w_state_nxt = TestLogicReset;
    end else if (w_tck_rise) begin
      w_state_nxt = tap_next_state(r_state, w_tms);
    end
    w_entering    = (w_state_nxt != r_state);
    w_capture_nxt = w_sel_user & w_entering & (w_state_nxt == CaptureDr);
    w_update_nxt  = w_sel_user & w_entering & (w_state_nxt == UpdateDr);
    w_tdo_oe_nxt  = (w_state_nxt == ShiftDr) | (w_state_nxt == ShiftIr);
  end

  // State register and strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= TestLogicReset;
      r_user_capture <= 1'b0;
      r_user_update  <= 1'b0;
      r_tdo_oe       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_user_capture <= w_capture_nxt;
      r_user_update  <= w_update_nxt;
      r_tdo_oe       <= w_tdo_oe_nxt;
    end
  end

  // IR/DR capture and shift on TCK rise in Capture/Shift; TDO on TCK fall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ir        <= IrWidth'(IrIdcode);
      r_ir_sr     <= '0;
      r_idcode_sr <= '0;
      r_user_sr   <= '0;
      r_bypass    <= 1'b0;
      r_tdo       <= 1'b0;
    end else begin
      if (w_state_nxt == TestLogicReset) begin
        r_ir <= IrWidth'(IrIdcode);
      end else if (w_state_nxt == UpdateIr && r_state != UpdateIr) begin
        r_ir <= r_ir_sr;
      end

      if (w_adv) begin
        case (r_state)
          CaptureIr: r_ir_sr <= IrWidth'(2'b01);
          ShiftIr:   r_ir_sr <= {w_tdi, r_ir_sr[IrWidth-1:1]};
          CaptureDr: begin
            if (w_sel_idcode) begin
              r_idcode_sr <= IdCode | 32'h1;
            end else if (w_sel_user) begin
              r_user_sr <= user_capture_i;
            end else begin
              r_bypass <= 1'b0;
            end
          end
          ShiftDr: begin
            if (w_sel_idcode) begin
              r_idcode_sr <= {w_tdi, r_idcode_sr[31:1]};
            end else if (w_sel_user) begin
              // Shift form that also works for a 1-bit user register
              r_user_sr <= (r_user_sr >> 1) | (UserDrWidth'(w_tdi) << (UserDrWidth - 1));
            end else begin
              r_bypass <= w_tdi;
            end
          end
          default: ;
        endcase
      end

      if (w_tck_fall) begin
        if (r_state == ShiftIr) begin
          r_tdo <= r_ir_sr[0];
        end else if (r_state == ShiftDr) begin
          r_tdo <= w_dr_lsb;
        end
      end
    end
  end

  assign jtag_tdo_o     = r_tdo;
  assign jtag_tdo_oe_o  = r_tdo_oe;
  assign tap_state_o    = r_state;
  assign user_capture_o = r_user_capture;
  assign user_update_o  = r_user_update;
  assign user_data_o    = r_user_sr;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Directed bench for jtag_tap_oversampled: TAP walk table, IDCODE, BYPASS,
// user DR capture/update, TRST abort, pause path and edge latency.
module tb_jtag_tap_oversampled;
  import jtag_tap_pkg::*;

  localparam int unsigned IrW = 5;
  localparam int unsigned UdW = 41;
  localparam logic [31:0] ExpIdcode = 32'h1000_0db3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tck = 1'b0;
  logic           tms = 1'b1;
  logic           tdi = 1'b0;
  logic           trst_n = 1'b1;
  logic           tdo;
  logic           tdo_oe;
  logic [3:0]     state;
  logic           ucap;
  logic           uupd;
  logic [UdW-1:0] ucap_data = '0;
  logic [UdW-1:0] udata;

  int n_chk = 0;
  int n_fail = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;
  int both_cnt = 0;
  int oe_pause_cnt = 0;
  logic [UdW-1:0] upd_data = '0;

  always #5 clk = ~clk;

  jtag_tap_oversampled dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .jtag_tck_i     (tck),
    .jtag_tms_i     (tms),
    .jtag_tdi_i     (tdi),
    .jtag_trst_ni   (trst_n),
    .jtag_tdo_o     (tdo),
    .jtag_tdo_oe_o  (tdo_oe),
    .tap_state_o    (state),
    .user_capture_o (ucap),
    .user_capture_i (ucap_data),
    .user_update_o  (uupd),
    .user_data_o    (udata)
  );

  // Strobe and enable monitor
  always @(negedge clk) begin
    if (ucap) cap_cnt++;
    if (uupd) begin
      upd_cnt++;
      upd_data = udata;
    end
    if (ucap && uupd) both_cnt++;
    if (state == PauseDr && tdo_oe) oe_pause_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One TCK period; returns TDO as seen just before the rise
  task automatic tck_bit(input logic t_ms, input logic t_di, output logic t_do);
    @(negedge clk);
    tms = t_ms;
    tdi = t_di;
    repeat (6) @(negedge clk);
    t_do = tdo;
    tck = 1'b1;
    repeat (6) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic tms_seq(input logic [7:0] seq, input int n);
    logic b;
    for (int i = 0; i < n; i++) tck_bit(seq[i], 1'b0, b);
  endtask

  task automatic shift_bits(input int n, input logic [63:0] din, input logic exit_last,
                            output logic [63:0] dout);
    logic b;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      tck_bit((i == n - 1) && exit_last, din[i], b);
      dout[i] = b;
    end
  endtask

  // From RunTestIdle, full IR scan back to RunTestIdle
  task automatic ir_scan(input logic [63:0] ir, output logic [63:0] dout);
    tms_seq(8'b0011, 4);
    shift_bits(IrW, ir, 1'b1, dout);
    tms_seq(8'b01, 2);
  endtask

  // From RunTestIdle, full DR scan back to RunTestIdle
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    tms_seq(8'b001, 3);
    shift_bits(n, din, 1'b1, dout);
    tms_seq(8'b01, 2);
  endtask

  typedef struct {
    logic       tms;
    logic       tdi;
    tap_state_e exp_state;
    logic       exp_oe;
  } vec_t;

  vec_t vecs [23];

  initial begin
    logic [63:0] d;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] din;
    logic [3:0]  s0;
    logic        b;
    int          c0;
    int          u0;
    int          n;
    int          exp_lat;

    // Walk through all 16 states starting from TestLogicReset
    vecs[0]  = '{1'b0, 1'b0, RunTestIdle,    1'b0};
    vecs[1]  = '{1'b1, 1'b0, SelectDr,       1'b0};
    vecs[2]  = '{1'b0, 1'b0, CaptureDr,      1'b0};
    vecs[3]  = '{1'b0, 1'b0, ShiftDr,        1'b1};
    vecs[4]  = '{1'b1, 1'b1, Exit1Dr,        1'b0};
    vecs[5]  = '{1'b0, 1'b0, PauseDr,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, Exit2Dr,        1'b0};
    vecs[7]  = '{1'b0, 1'b0, ShiftDr,        1'b1};
    vecs[8]  = '{1'b1, 1'b0, Exit1Dr,        1'b0};
    vecs[9]  = '{1'b1, 1'b0, UpdateDr,       1'b0};
    vecs[10] = '{1'b1, 1'b0, SelectDr,       1'b0};
    vecs[11] = '{1'b1, 1'b0, SelectIr,       1'b0};
    vecs[12] = '{1'b0, 1'b0, CaptureIr,      1'b0};
    vecs[13] = '{1'b0, 1'b0, ShiftIr,        1'b1};
    vecs[14] = '{1'b1, 1'b0, Exit1Ir,        1'b0};
    vecs[15] = '{1'b0, 1'b0, PauseIr,        1'b0};
    vecs[16] = '{1'b1, 1'b0, Exit2Ir,        1'b0};
    vecs[17] = '{1'b1, 1'b0, UpdateIr,       1'b0};
    vecs[18] = '{1'b0, 1'b0, RunTestIdle,    1'b0};
    vecs[19] = '{1'b1, 1'b0, SelectDr,       1'b0};
    vecs[20] = '{1'b1, 1'b0, SelectIr,       1'b0};
    vecs[21] = '{1'b1, 1'b0, TestLogicReset, 1'b0};
    vecs[22] = '{1'b1, 1'b0, TestLogicReset, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset state", 64'(state), 64'(TestLogicReset));
    chk("reset tdo", 64'(tdo), 64'h0);
    chk("reset tdo_oe", 64'(tdo_oe), 64'h0);
    chk("reset capture", 64'(ucap), 64'h0);
    chk("reset update", 64'(uupd), 64'h0);
    chk("reset user_data", 64'(udata), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      tck_bit(vecs[i].tms, vecs[i].tdi, b);
      chk($sformatf("walk%0d state", i), 64'(state), 64'(vecs[i].exp_state));
      chk($sformatf("walk%0d tdo_oe", i), 64'(tdo_oe), 64'(vecs[i].exp_oe));
    end
    chk("walk no capture", 64'(cap_cnt), 64'h0);

    // IDCODE read after reset
    tms_seq(8'h1F, 5);
    chk("tlr after 5 tms", 64'(state), 64'(TestLogicReset));
    tms_seq(8'b0010, 4);
    chk("reach ShiftDr", 64'(state), 64'(ShiftDr));
    shift_bits(32, 64'h0, 1'b0, d);
    chk("still ShiftDr", 64'(state), 64'(ShiftDr));
    chk("idcode word", 64'(d[31:0]), 64'(ExpIdcode));
    tms_seq(8'b011, 3);
    chk("idle after idcode", 64'(state), 64'(RunTestIdle));

    // BYPASS
    ir_scan(64'h1F, d);
    chk("ir capture bypass", 64'(d[4:0]), 64'h01);
    dr_scan(9, 64'h0A5, d);
    chk("bypass delay", 64'(d[8:0]), 64'h14A);

    // User DR capture and update
    ucap_data = 41'h1_2345_6789;
    ir_scan(64'h11, d);
    chk("ir capture user", 64'(d[4:0]), 64'h01);
    c0 = cap_cnt;
    u0 = upd_cnt;
    dr_scan(41, 64'h0_DEAD_BEEF, d);
    chk("user capture pulses", 64'(cap_cnt - c0), 64'd1);
    chk("user tdo word", 64'(d[40:0]), 64'h1_2345_6789);
    chk("user update pulses", 64'(upd_cnt - u0), 64'd1);
    chk("user update data", 64'(upd_data), 64'h0_DEAD_BEEF);

    // TRST during a user shift
    c0 = cap_cnt;
    u0 = upd_cnt;
    tms_seq(8'b001, 3);
    shift_bits(10, 64'h3FF, 1'b0, d);
    chk("trst pre ShiftDr", 64'(state), 64'(ShiftDr));
    @(negedge clk);
    trst_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("trst state", 64'(state), 64'(TestLogicReset));
    trst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("trst no update", 64'(upd_cnt - u0), 64'd0);
    tms_seq(8'b0, 1);
    dr_scan(32, 64'h0, d);
    chk("trst ir idcode", 64'(d[31:0]), 64'(ExpIdcode));
    chk("trst capture count", 64'(cap_cnt - c0), 64'd1);

    // Pause path in the middle of a user shift
    ucap_data = 41'h1_0F0F_0F0F;
    din = 64'h0A_BCDE_F012;
    ir_scan(64'h11, d);
    c0 = cap_cnt;
    u0 = upd_cnt;
    tms_seq(8'b001, 3);
    shift_bits(20, din, 1'b1, d1);
    tms_seq(8'b0, 1);
    tms_seq(8'b0, 4);
    chk("pause state", 64'(state), 64'(PauseDr));
    chk("pause tdo_oe", 64'(tdo_oe), 64'h0);
    tms_seq(8'b1, 1);
    tms_seq(8'b0, 1);
    chk("resume ShiftDr", 64'(state), 64'(ShiftDr));
    shift_bits(21, din >> 20, 1'b1, d2);
    tms_seq(8'b01, 2);
    d = {44'h0, d1[19:0]} | ({43'h0, d2[20:0]} << 20);
    chk("pause tdo word", 64'(d[40:0]), 64'h1_0F0F_0F0F);
    chk("pause update pulses", 64'(upd_cnt - u0), 64'd1);
    chk("pause update data", 64'(upd_data), 64'(din[40:0]));
    chk("pause capture pulses", 64'(cap_cnt - c0), 64'd1);

    // Pad TCK rise to state change latency
`ifdef JTAG_TAP_SYNC_EN
    exp_lat = 4;
`else
    exp_lat = 3;
`endif
    @(negedge clk);
    tms = 1'b1;
    repeat (8) @(negedge clk);
    s0 = state;
    tck = 1'b1;
    n = 0;
    while (state == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tck latency", 64'(n), 64'(exp_lat));
    repeat (6) @(negedge clk);
    tck = 1'b0;
    repeat (8) @(negedge clk);
    chk("latency state", 64'(state), 64'(SelectDr));

    chk("strobe overlap", 64'(both_cnt), 64'd0);
    chk("oe in pause", 64'(oe_pause_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
